// File: rtl/tt_vec_load_queue.sv
// Load-return queue between the OVI load-data interface and the VRF writeback arbiter.
// First-word-fall-through FIFO with per-beat credit return and flush-driven credit drain.
module tt_vec_load_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned SEQ_W  = 34
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_ld_valid,
    input  logic [DATA_W-1:0]        i_ld_data,
    input  logic [SEQ_W-1:0]         i_ld_seq_id,
    input  logic                     i_flush,
    output logic                     o_wb_valid,
    output logic [DATA_W-1:0]        o_wb_data,
    output logic [SEQ_W-1:0]         o_wb_seq_id,
    input  logic                     i_wb_ready,
    output logic                     o_ld_credit,
    output logic                     o_lq_empty,
    output logic                     o_lq_full,
    output logic [$clog2(DEPTH):0]   o_lq_count,
    output logic                     o_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [SEQ_W-1:0]  mem_seq  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  pend_cnt;
    logic              credit_q;
    logic              overflow_q;

    logic              full;
    logic              pop_req;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              ovf_evt;
    logic [CNT_W:0]    credit_avail;
    logic [CNT_W:0]    credit_left;
    logic [CNT_W-1:0]  pend_next;

    always_comb begin
        full     = (count == CNT_W'(DEPTH));
        pop_req  = (count != '0) && i_wb_ready;
        push_req = i_ld_valid && (!full || pop_req);
        push     = push_req && !i_flush;
        pop      = pop_req && !i_flush;
        ovf_evt  = i_ld_valid && full && !pop_req;
    end

    // Pops, flushed entries and carried-over credits merge into one stream drained at 1/cycle.
    always_comb begin
        credit_avail = {1'b0, pend_cnt} + (CNT_W+1)'(pop);
        if (i_flush) begin
            credit_avail = credit_avail + {1'b0, count};
        end
        credit_left = '0;
        if (credit_avail != '0) begin
            credit_left = credit_avail - (CNT_W+1)'(1);
        end
        if (credit_left > (CNT_W+1)'(DEPTH)) begin
            pend_next = CNT_W'(DEPTH);
        end else begin
            pend_next = credit_left[CNT_W-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pend_cnt   <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
            credit_q <= (credit_avail != '0);
            pend_cnt <= pend_next;
            if (ovf_evt) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_data[wr_ptr] <= i_ld_data;
            mem_seq[wr_ptr]  <= i_ld_seq_id;
        end
    end

    always_comb begin
        o_wb_valid  = (count != '0);
        o_wb_data   = mem_data[rd_ptr];
        o_wb_seq_id = mem_seq[rd_ptr];
        o_ld_credit = credit_q;
        o_lq_empty  = (count == '0);
        o_lq_full   = full;
        o_lq_count  = count;
        o_overflow  = overflow_q;
    end

endmodule
